// File: rtl/line_ram_arbiter_pkg.sv
// Shared types and default widths for the scaler line-buffer RAM.
// Grant and command-state enums used by the arbiter and its RR core.
package scaler_ram_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 30;

    typedef enum logic {
        GNT_WR = 1'b0,
        GNT_RD = 1'b1
    } grant_e;

    typedef enum logic [1:0] {
        IDLE,
        WR_CMD,
        RD_CMD
    } state_e;

endpackage

// File: rtl/line_ram_arbiter_if.sv
// Requester handshakes plus RAM bus of one line-buffer port.
// The arbiter sits on the slave side; the surroundings drive the master side.
interface line_ram_arbiter_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 30
);
    logic                  i_wr_valid;
    logic                  o_wr_ready;
    logic [ADDR_WIDTH-1:0] i_wr_addr;
    logic [DATA_WIDTH-1:0] i_wr_data;
    logic                  i_rd_valid;
    logic                  o_rd_ready;
    logic [ADDR_WIDTH-1:0] i_rd_addr;
    logic                  o_rd_dval;
    logic [DATA_WIDTH-1:0] o_rd_data;
    logic                  o_ram_cs;
    logic                  o_ram_we;
    logic [ADDR_WIDTH-1:0] o_ram_addr;
    logic [DATA_WIDTH-1:0] o_ram_din;
    logic [DATA_WIDTH-1:0] i_ram_dout;

    modport slave (
        input  i_wr_valid, i_wr_addr, i_wr_data,
        input  i_rd_valid, i_rd_addr, i_ram_dout,
        output o_wr_ready, o_rd_ready, o_rd_dval, o_rd_data,
        output o_ram_cs, o_ram_we, o_ram_addr, o_ram_din
    );

    modport master (
        output i_wr_valid, i_wr_addr, i_wr_data,
        output i_rd_valid, i_rd_addr, i_ram_dout,
        input  o_wr_ready, o_rd_ready, o_rd_dval, o_rd_data,
        input  o_ram_cs, o_ram_we, o_ram_addr, o_ram_din
    );
endinterface

// File: rtl/line_ram_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; req[0]=writer, req[1]=reader.
// last_grant only moves on an accepted grant.
import scaler_ram_pkg::*;

module rr_arb2 (
    input  logic       clk,
    input  logic       i_rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);
    grant_e last_q;

    assign gnt[0] = req[0] && (!req[1] || last_q == GNT_RD);
    assign gnt[1] = req[1] && (!req[0] || last_q == GNT_WR);

    always_ff @(posedge clk) begin
        if (i_rst) begin
            last_q <= GNT_RD;
        end else if (accept) begin
            last_q <= gnt[1] ? GNT_RD : GNT_WR;
        end
    end
endmodule

// File: rtl/line_ram_arbiter.sv
// Shares a single-port line RAM between the pixel writer and tap fetch.
// RAM command, read strobe/data and contention counter are all registered.
import scaler_ram_pkg::*;

module line_ram_arbiter #(
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int DATA_WIDTH = DATA_W,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 i_rst,
    line_ram_arbiter_if.slave    bus,
    output logic [CNT_WIDTH-1:0] o_conflict_cnt
);
    logic [1:0]            gnt;
    logic                  acc_wr;
    logic                  acc_rd;
    state_e                state_q;
    state_e                state_d;
    logic                  cs_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] din_q;
    logic                  dval_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [CNT_WIDTH-1:0]  cnt_q;

    rr_arb2 u_arb (
        .clk    (clk),
        .i_rst  (i_rst),
        .req    ({bus.i_rd_valid, bus.i_wr_valid}),
        .accept (acc_wr | acc_rd),
        .gnt    (gnt)
    );

    // No handshake may complete while reset is held.
    assign acc_wr = gnt[0] & ~i_rst;
    assign acc_rd = gnt[1] & ~i_rst;

    always_comb begin
        state_d = IDLE;
        if (acc_wr) begin
            state_d = WR_CMD;
        end else if (acc_rd) begin
            state_d = RD_CMD;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            cs_q      <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            din_q     <= '0;
            dval_q    <= 1'b0;
            rd_data_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            cs_q    <= acc_wr | acc_rd;
            we_q    <= acc_wr;
            if (acc_wr) begin
                addr_q <= bus.i_wr_addr;
                din_q  <= bus.i_wr_data;
            end else if (acc_rd) begin
                addr_q <= bus.i_rd_addr;
            end
            dval_q <= (state_q == RD_CMD);
            if (state_q == RD_CMD) begin
                rd_data_q <= bus.i_ram_dout;
            end
            if (bus.i_wr_valid && bus.i_rd_valid && cnt_q != '1) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.o_wr_ready = acc_wr;
    assign bus.o_rd_ready = acc_rd;
    assign bus.o_ram_cs   = cs_q;
    assign bus.o_ram_we   = we_q;
    assign bus.o_ram_addr = addr_q;
    assign bus.o_ram_din  = din_q;
    assign bus.o_rd_dval  = dval_q;
    assign bus.o_rd_data  = rd_data_q;
    assign o_conflict_cnt = cnt_q;
endmodule

// File: tb/tb_line_ram_arbiter.sv
// Directed vector bench for line_ram_arbiter with a behavioural line RAM.
// A second instance with a 4-bit counter covers saturation.
module tb_line_ram_arbiter;

    logic clk;
    logic rst;
    logic rst2;
    logic [15:0] cnt;
    logic [3:0]  cnt2;
    logic [29:0] mem [256];
    logic        loaded = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;

    line_ram_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(30)) b ();
    line_ram_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(30)) b2 ();

    line_ram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(30), .CNT_WIDTH(16)) dut (
        .clk            (clk),
        .i_rst          (rst),
        .bus            (b.slave),
        .o_conflict_cnt (cnt)
    );

    line_ram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(30), .CNT_WIDTH(4)) dut2 (
        .clk            (clk),
        .i_rst          (rst2),
        .bus            (b2.slave),
        .o_conflict_cnt (cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line RAM model: preloaded with addr+0x100, combinational read.
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= 30'(i + 'h100);
            loaded <= 1'b1;
        end else if (b.o_ram_cs && b.o_ram_we) begin
            mem[b.o_ram_addr] <= b.o_ram_din;
        end
    end
    assign b.i_ram_dout = (b.o_ram_cs && !b.o_ram_we) ? mem[b.o_ram_addr] : '0;
    assign b2.i_ram_dout = '0;

    typedef struct {
        logic        rst;
        logic        wv;
        logic [7:0]  wa;
        logic [29:0] wd;
        logic        rv;
        logic [7:0]  ra;
        logic        ewr;
        logic        erd;
        logic        ecs;
        logic        ewe;
        logic [7:0]  eaddr;
        logic        edv;
        logic [29:0] edata;
        logic [15:0] ecnt;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic wv, input logic [7:0] wa,
                       input logic [29:0] wd, input logic rv, input logic [7:0] ra,
                       input logic ewr, input logic erd, input logic ecs,
                       input logic ewe, input logic [7:0] eaddr, input logic edv,
                       input logic [29:0] edata, input logic [15:0] ecnt);
        vec_t v;
        v.rst = r; v.wv = wv; v.wa = wa; v.wd = wd; v.rv = rv; v.ra = ra;
        v.ewr = ewr; v.erd = erd; v.ecs = ecs; v.ewe = ewe;
        v.eaddr = eaddr; v.edv = edv; v.edata = edata; v.ecnt = ecnt;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rst2 = 1'b1;
        b.i_wr_valid = 0; b.i_wr_addr = 0; b.i_wr_data = 0;
        b.i_rd_valid = 0; b.i_rd_addr = 0;
        b2.i_wr_valid = 0; b2.i_wr_addr = 0; b2.i_wr_data = 0;
        b2.i_rd_valid = 0; b2.i_rd_addr = 0;

        // reset with both valids high
        for (int i = 0; i < 3; i++)
            add(1,1,8'h05,30'h2AAAAAAA,1,8'h05, 0,0,0,0,8'h00,0,30'h0,0);
        // first conflict after reset goes to the writer, then RAW read
        add(0,1,8'h05,30'h2AAAAAAA,1,8'h05, 1,0,1,1,8'h05,0,30'h0,1);
        add(0,0,8'h00,30'h0,1,8'h05,        0,1,1,0,8'h05,0,30'h0,1);
        add(0,0,8'h00,30'h0,0,8'h00,        0,0,0,0,8'h05,1,30'h2AAAAAAA,1);
        add(0,0,8'h00,30'h0,0,8'h00,        0,0,0,0,8'h05,0,30'h2AAAAAAA,1);
        // contention: WR,RD alternate
        add(0,1,8'h10,30'h200,1,8'h20, 1,0,1,1,8'h10,0,30'h2AAAAAAA,2);
        add(0,1,8'h11,30'h201,1,8'h21, 0,1,1,0,8'h21,0,30'h2AAAAAAA,3);
        add(0,1,8'h12,30'h202,1,8'h22, 1,0,1,1,8'h12,1,30'h121,4);
        add(0,1,8'h13,30'h203,1,8'h23, 0,1,1,0,8'h23,0,30'h121,5);
        add(0,1,8'h14,30'h204,1,8'h24, 1,0,1,1,8'h14,1,30'h123,6);
        add(0,1,8'h15,30'h205,1,8'h25, 0,1,1,0,8'h25,0,30'h123,7);
        add(0,0,8'h00,30'h0,0,8'h00,   0,0,0,0,8'h25,1,30'h125,7);
        add(0,0,8'h00,30'h0,0,8'h00,   0,0,0,0,8'h25,0,30'h125,7);
        // back-to-back reads
        add(0,0,8'h00,30'h0,1,8'h00, 0,1,1,0,8'h00,0,30'h125,7);
        add(0,0,8'h00,30'h0,1,8'h01, 0,1,1,0,8'h01,1,30'h100,7);
        add(0,0,8'h00,30'h0,1,8'h02, 0,1,1,0,8'h02,1,30'h101,7);
        add(0,0,8'h00,30'h0,1,8'h03, 0,1,1,0,8'h03,1,30'h102,7);
        add(0,0,8'h00,30'h0,0,8'h00, 0,0,0,0,8'h03,1,30'h103,7);
        add(0,0,8'h00,30'h0,0,8'h00, 0,0,0,0,8'h03,0,30'h103,7);
        // reset while a read is in flight
        add(0,0,8'h00,30'h0,1,8'h07, 0,1,1,0,8'h07,0,30'h103,7);
        add(1,0,8'h00,30'h0,1,8'h07, 0,0,0,0,8'h00,0,30'h0,0);
        add(0,0,8'h00,30'h0,0,8'h00, 0,0,0,0,8'h00,0,30'h0,0);

        foreach (vq[i]) begin
            rst          = vq[i].rst;
            b.i_wr_valid = vq[i].wv;
            b.i_wr_addr  = vq[i].wa;
            b.i_wr_data  = vq[i].wd;
            b.i_rd_valid = vq[i].rv;
            b.i_rd_addr  = vq[i].ra;
            #1;
            chk($sformatf("v%0d wr_ready", i), 32'(b.o_wr_ready), 32'(vq[i].ewr));
            chk($sformatf("v%0d rd_ready", i), 32'(b.o_rd_ready), 32'(vq[i].erd));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d cs", i),    32'(b.o_ram_cs),   32'(vq[i].ecs));
            chk($sformatf("v%0d we", i),    32'(b.o_ram_we),   32'(vq[i].ewe));
            chk($sformatf("v%0d addr", i),  32'(b.o_ram_addr), 32'(vq[i].eaddr));
            chk($sformatf("v%0d dval", i),  32'(b.o_rd_dval),  32'(vq[i].edv));
            chk($sformatf("v%0d data", i),  32'(b.o_rd_data),  32'(vq[i].edata));
            chk($sformatf("v%0d cnt", i),   32'(cnt),          32'(vq[i].ecnt));
        end

        // written data landed in RAM during contention
        chk("mem[10]", 32'(mem[8'h10]), 32'h200);
        chk("mem[14]", 32'(mem[8'h14]), 32'h204);

        // 4-bit counter saturation
        chk("sat reset cnt", 32'(cnt2), 32'h0);
        rst2 = 1'b0;
        b2.i_wr_valid = 1'b1;
        b2.i_rd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("sat cnt c%0d", i), 32'(cnt2), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
        end
        b2.i_wr_valid = 1'b0;
        b2.i_rd_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("sat cnt hold", 32'(cnt2), 32'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
